// File: rtl/smem_bck_store_if.sv
// Bundle of the stage-1 write ports, the prev-list read port and the mem drain stream for smem_bck_store.
// slave is the store's side; master is the side that drives the store.
interface smem_bck_store_if #(
  parameter int ADDR_W = 7
);
  logic              stall;
  logic              swap;

  logic              store_valid_curr;
  logic [63:0]       curr_x_0;
  logic [63:0]       curr_x_1;
  logic [63:0]       curr_x_2;
  logic [63:0]       curr_x_info;
  logic [ADDR_W-1:0] curr_x_addr;

  logic              store_valid_mem;
  logic [63:0]       mem_x_0;
  logic [63:0]       mem_x_1;
  logic [63:0]       mem_x_2;
  logic [63:0]       mem_x_info;
  logic [ADDR_W-1:0] mem_x_addr;

  logic              prev_rd_en;
  logic [ADDR_W-1:0] prev_rd_addr;
  logic [255:0]      prev_rd_data;

  logic              drain_start;
  logic [ADDR_W-1:0] drain_count;
  logic              out_valid;
  logic              out_ready;
  logic [255:0]      out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              drain_done;
  logic              busy;
  logic              err;

  modport slave (
    input  stall, swap,
    input  store_valid_curr, curr_x_0, curr_x_1, curr_x_2, curr_x_info, curr_x_addr,
    input  store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
    input  prev_rd_en, prev_rd_addr,
    output prev_rd_data,
    input  drain_start, drain_count, out_ready,
    output out_valid, out_data, out_addr, drain_done, busy, err
  );

  modport master (
    output stall, swap,
    output store_valid_curr, curr_x_0, curr_x_1, curr_x_2, curr_x_info, curr_x_addr,
    output store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
    output prev_rd_en, prev_rd_addr,
    input  prev_rd_data,
    output drain_start, drain_count, out_ready,
    input  out_valid, out_data, out_addr, drain_done, busy, err
  );
endinterface

// File: rtl/smem_bck_store.sv
// Backward-extension store: ping-pong curr/prev interval banks plus a mem buffer
// that is streamed out over valid/ready when the backward pass ends.
module smem_bck_store #(
  parameter int ADDR_W = 7
) (
  input logic             clk,
  input logic             rst,
  smem_bck_store_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_s;
  logic              last_s;

  logic              bank_sel_r;
  logic              err_r;
  logic [255:0]      prev_rd_data_r;
  logic [255:0]      out_data_r;
  logic [ADDR_W-1:0] out_addr_r;

  logic [255:0]      curr_ram_r [2][DEPTH];
  logic [255:0]      mem_ram_r [DEPTH];

  logic              curr_we_s;
  logic              mem_req_s;
  logic              mem_we_s;
  logic              prev_re_s;

  function automatic logic [255:0] pack_entry(input logic [63:0] x0, input logic [63:0] x1,
                                              input logic [63:0] x2, input logic [63:0] info);
    return {x0, x1, x2, info};
  endfunction

  assign curr_we_s = bus.store_valid_curr & ~bus.stall;
  assign mem_req_s = bus.store_valid_mem & ~bus.stall;
  assign mem_we_s  = mem_req_s & (state_r == IDLE);
  assign prev_re_s = bus.prev_rd_en & ~bus.stall;

  // Bank select toggles on swap regardless of stall; err latches a mem write dropped mid-drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_sel_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (bus.swap) begin
        bank_sel_r <= ~bank_sel_r;
      end
      if (mem_req_s && (state_r != IDLE)) begin
        err_r <= 1'b1;
      end
    end
  end

  // Interval RAMs are not reset; writes use the pre-swap bank select.
  always_ff @(posedge clk) begin
    if (curr_we_s) begin
      curr_ram_r[bank_sel_r][bus.curr_x_addr] <=
        pack_entry(bus.curr_x_0, bus.curr_x_1, bus.curr_x_2, bus.curr_x_info);
    end
    if (mem_we_s) begin
      mem_ram_r[bus.mem_x_addr] <=
        pack_entry(bus.mem_x_0, bus.mem_x_1, bus.mem_x_2, bus.mem_x_info);
    end
  end

  // Previous-iteration read port; holds its value while stalled or idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_rd_data_r <= 256'd0;
    end else if (prev_re_s) begin
      prev_rd_data_r <= curr_ram_r[~bank_sel_r][bus.prev_rd_addr];
    end
  end

  // Drain state, pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      ptr_r   <= {ADDR_W{1'b0}};
      cnt_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
    end
  end

  // cnt-1 is only meaningful for a non-zero count, which OUT always has.
  assign last_s = (cnt_r != {ADDR_W{1'b0}}) &&
                  (ptr_r == (cnt_r - {{(ADDR_W-1){1'b0}}, 1'b1}));

  // Drain next-state logic.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.drain_start) begin
          cnt_s = bus.drain_count;
          ptr_s = {ADDR_W{1'b0}};
          if (bus.drain_count == {ADDR_W{1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        state_s = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          if (last_s) begin
            state_s = DONE;
          end else begin
            ptr_s   = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_s = RD;
          end
        end else begin
          state_s = OUT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Drain output register, loaded only in RD so it holds through backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data_r <= 256'd0;
      out_addr_r <= {ADDR_W{1'b0}};
    end else if (state_r == RD) begin
      out_data_r <= mem_ram_r[ptr_r];
      out_addr_r <= ptr_r;
    end
  end

  assign bus.prev_rd_data = prev_rd_data_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_addr     = out_addr_r;
  assign bus.out_valid    = (state_r == OUT);
  assign bus.drain_done   = (state_r == DONE);
  assign bus.busy         = (state_r != IDLE);
  assign bus.err          = err_r;
endmodule

// File: tb/tb_smem_bck_store.sv
// Directed bench for smem_bck_store: bank ping-pong, stall, drain with backpressure,
// zero-length drain, dropped mem writes and reset in the middle of a drain.
module tb_smem_bck_store;
  localparam int ADDR_W = 7;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [255:0] ent_a;
  logic [255:0] v0;
  logic [255:0] v1;
  logic [255:0] old_v;
  logic [255:0] new_v;
  logic [255:0] z_v;
  logic [255:0] exp_mem [3];

  smem_bck_store_if #(.ADDR_W(ADDR_W)) bus ();

  smem_bck_store #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_curr(input logic [ADDR_W-1:0] addr, input logic [255:0] d);
    bus.curr_x_addr = addr;
    bus.curr_x_0    = d[255:192];
    bus.curr_x_1    = d[191:128];
    bus.curr_x_2    = d[127:64];
    bus.curr_x_info = d[63:0];
  endtask

  task automatic set_mem(input logic [ADDR_W-1:0] addr, input logic [255:0] d);
    bus.mem_x_addr = addr;
    bus.mem_x_0    = d[255:192];
    bus.mem_x_1    = d[191:128];
    bus.mem_x_2    = d[127:64];
    bus.mem_x_info = d[63:0];
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ent_a      = {64'd1, 64'd2, 64'd3, 64'd4};
    v0         = {64'h1000, 64'h1001, 64'h1002, 64'h1003};
    v1         = {64'h2000, 64'h2001, 64'h2002, 64'h2003};
    old_v      = {64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD};
    new_v      = {64'h5555, 64'h6666, 64'h7777, 64'h8888};
    z_v        = {64'hDEAD, 64'hBEEF, 64'hF00D, 64'hCAFE};
    exp_mem[0] = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
    exp_mem[1] = {64'hB0, 64'hB1, 64'hB2, 64'hB3};
    exp_mem[2] = {64'hC0, 64'hC1, 64'hC2, 64'hC3};

    rst = 1'b0;
    bus.stall = 1'b0;
    bus.swap = 1'b0;
    bus.store_valid_curr = 1'b0;
    bus.store_valid_mem = 1'b0;
    set_curr(7'd0, 256'd0);
    set_mem(7'd0, 256'd0);
    bus.prev_rd_en = 1'b0;
    bus.prev_rd_addr = 7'd0;
    bus.drain_start = 1'b0;
    bus.drain_count = 7'd0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_prev_rd_data", bus.prev_rd_data, 256'd0);
    chk("rst_out_data", bus.out_data, 256'd0);
    chk("rst_out_addr", {249'd0, bus.out_addr}, 256'd0);
    chk("rst_out_valid", {255'd0, bus.out_valid}, 256'd0);
    chk("rst_drain_done", {255'd0, bus.drain_done}, 256'd0);
    chk("rst_busy", {255'd0, bus.busy}, 256'd0);
    chk("rst_err", {255'd0, bus.err}, 256'd0);
    rst = 1'b1;

    // write bank0[5], swap, read it back as prev
    bus.store_valid_curr = 1'b1;
    set_curr(7'd5, ent_a);
    cyc();
    bus.store_valid_curr = 1'b0;
    bus.swap = 1'b1;
    cyc();
    bus.swap = 1'b0;
    bus.prev_rd_en = 1'b1;
    bus.prev_rd_addr = 7'd5;
    cyc();
    chk("curr_swap_read", bus.prev_rd_data, ent_a);

    // same-cycle swap + write + read all use the pre-swap bank select
    bus.store_valid_curr = 1'b1;
    set_curr(7'd20, v1);
    bus.swap = 1'b1;
    bus.prev_rd_addr = 7'd5;
    cyc();
    chk("swap_same_cycle_read", bus.prev_rd_data, ent_a);
    bus.swap = 1'b0;
    set_curr(7'd20, v0);
    bus.prev_rd_addr = 7'd20;
    cyc();
    chk("swap_same_cycle_write", bus.prev_rd_data, v1);
    bus.store_valid_curr = 1'b0;
    bus.prev_rd_en = 1'b0;
    bus.swap = 1'b1;
    cyc();
    bus.swap = 1'b0;
    bus.prev_rd_en = 1'b1;
    cyc();
    chk("read_bank0_addr20", bus.prev_rd_data, v0);

    // stall: curr write suppressed, prev read frozen, swap still honoured
    bus.prev_rd_en = 1'b0;
    bus.store_valid_curr = 1'b1;
    set_curr(7'd9, old_v);
    cyc();
    bus.stall = 1'b1;
    set_curr(7'd9, new_v);
    bus.prev_rd_en = 1'b1;
    bus.prev_rd_addr = 7'd5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_prev_hold", bus.prev_rd_data, v0);
    end
    bus.store_valid_curr = 1'b0;
    bus.prev_rd_en = 1'b0;
    bus.swap = 1'b1;
    cyc();
    bus.swap = 1'b0;
    bus.stall = 1'b0;
    bus.prev_rd_en = 1'b1;
    bus.prev_rd_addr = 7'd9;
    cyc();
    chk("stall_no_write", bus.prev_rd_data, old_v);
    bus.prev_rd_en = 1'b0;
    bus.swap = 1'b1;
    cyc();
    bus.swap = 1'b0;

    // fill mem[0..2] and drain 3 entries with backpressure on each
    bus.store_valid_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_mem(i[ADDR_W-1:0], exp_mem[i]);
      cyc();
    end
    bus.store_valid_mem = 1'b0;
    bus.drain_start = 1'b1;
    bus.drain_count = 7'd3;
    cyc();
    bus.drain_start = 1'b0;
    chk("drain_rd_busy", {255'd0, bus.busy}, 256'd1);
    chk("drain_rd_no_valid", {255'd0, bus.out_valid}, 256'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("drain_valid", {255'd0, bus.out_valid}, 256'd1);
      chk("drain_data", bus.out_data, exp_mem[i]);
      chk("drain_addr", {249'd0, bus.out_addr}, 256'(i));
      bus.out_ready = 1'b0;
      cyc();
      chk("hold_valid", {255'd0, bus.out_valid}, 256'd1);
      chk("hold_data", bus.out_data, exp_mem[i]);
      chk("hold_addr", {249'd0, bus.out_addr}, 256'(i));
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      chk("post_hs_no_valid", {255'd0, bus.out_valid}, 256'd0);
      if (i < 2) begin
        chk("no_early_done", {255'd0, bus.drain_done}, 256'd0);
        cyc();
      end else begin
        chk("drain_done_pulse", {255'd0, bus.drain_done}, 256'd1);
        cyc();
        chk("drain_done_clear", {255'd0, bus.drain_done}, 256'd0);
        chk("busy_fall", {255'd0, bus.busy}, 256'd0);
      end
    end

    // zero-length drain
    bus.drain_start = 1'b1;
    bus.drain_count = 7'd0;
    cyc();
    bus.drain_start = 1'b0;
    chk("cnt0_done", {255'd0, bus.drain_done}, 256'd1);
    chk("cnt0_no_valid", {255'd0, bus.out_valid}, 256'd0);
    cyc();
    chk("cnt0_done_clear", {255'd0, bus.drain_done}, 256'd0);
    chk("cnt0_idle", {255'd0, bus.busy}, 256'd0);
    chk("cnt0_never_valid", {255'd0, bus.out_valid}, 256'd0);

    // mem write during drain is dropped and sets sticky err; then reset mid-drain
    bus.drain_start = 1'b1;
    bus.drain_count = 7'd2;
    cyc();
    bus.drain_start = 1'b0;
    bus.store_valid_mem = 1'b1;
    set_mem(7'd0, z_v);
    cyc();
    bus.store_valid_mem = 1'b0;
    chk("err_set", {255'd0, bus.err}, 256'd1);
    chk("mid_valid", {255'd0, bus.out_valid}, 256'd1);
    cyc();
    cyc();
    chk("err_sticky", {255'd0, bus.err}, 256'd1);
    rst = 1'b0;
    cyc();
    chk("midrst_out_valid", {255'd0, bus.out_valid}, 256'd0);
    chk("midrst_busy", {255'd0, bus.busy}, 256'd0);
    chk("midrst_err", {255'd0, bus.err}, 256'd0);
    chk("midrst_no_done", {255'd0, bus.drain_done}, 256'd0);
    rst = 1'b1;

    // bank_sel back to 0: prev bank is bank1, which holds v1 at addr 20
    bus.prev_rd_en = 1'b1;
    bus.prev_rd_addr = 7'd20;
    cyc();
    bus.prev_rd_en = 1'b0;
    chk("midrst_bank_sel", bus.prev_rd_data, v1);

    // mem[0] still holds the pre-drain value
    bus.drain_start = 1'b1;
    bus.drain_count = 7'd1;
    cyc();
    bus.drain_start = 1'b0;
    cyc();
    chk("dropped_write_data", bus.out_data, exp_mem[0]);
    chk("dropped_write_addr", {249'd0, bus.out_addr}, 256'd0);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("single_done", {255'd0, bus.drain_done}, 256'd1);
    cyc();
    chk("single_idle", {255'd0, bus.busy}, 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
